// File: rtl/mul_seq_pkg.sv
// Shared types and defaults for the repeated-addition multiplier controller.
package mul_seq_pkg;

  localparam int unsigned ITER_W_DEF   = 16;
  localparam logic [15:0] MAX_ITER_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

endpackage

// File: rtl/mul_iter_cnt.sv
// Iteration counter for the ADD loop: clears on B acceptance, counts ld_p pulses,
// and flags when the allowed iteration budget is used up.
module mul_iter_cnt
  import mul_seq_pkg::*;
#(
  parameter int unsigned           ITER_W   = ITER_W_DEF,
  parameter logic [ITER_W-1:0]     MAX_ITER = ITER_W'(MAX_ITER_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ITER_W-1:0] cnt_o,
  output logic              at_max_o
);

  logic [ITER_W-1:0] cnt_q;
  logic [ITER_W-1:0] cnt_d;

  assign at_max_o = (cnt_q == MAX_ITER);
  assign cnt_o    = cnt_q;

  // Saturating at the limit keeps the count from ever wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + ITER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Control FSM for the repeated-addition multiplier: loads A and B over the bus,
// adds A into P while decrementing B, then reports done or a timeout error.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned       DATA_W   = 15,
  parameter int unsigned       ITER_W   = ITER_W_DEF,
  parameter logic [ITER_W-1:0] MAX_ITER = ITER_W'(MAX_ITER_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              eqz,
  output logic              ld_a,
  output logic              ld_b,
  output logic              clr_p,
  output logic              ld_p,
  output logic              dec_b,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              res_ack,
  output logic [ITER_W-1:0] iter_cnt
);

  generate
    if (DATA_W < 1 || ITER_W < 1) begin : g_bad_param
      $error("mul_seq_ctrl: DATA_W and ITER_W must be positive");
    end
  endgenerate

  state_e state_q;
  state_e state_d;
  logic   at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // eqz outranks the iteration limit so B reaching zero on the last allowed add still finishes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start)    state_d = LOAD_A;
      LOAD_A: if (in_valid) state_d = LOAD_B;
      LOAD_B: if (in_valid) state_d = ADD;
      ADD: begin
        if (eqz)         state_d = DONE;
        else if (at_max) state_d = ERR;
      end
      DONE:   if (res_ack)  state_d = IDLE;
      ERR:    if (res_ack)  state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Strobes are suppressed while rst is high so a mid-operation reset disturbs nothing.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    clr_p    = 1'b0;
    ld_p     = 1'b0;
    dec_b    = 1'b0;
    case (state_q)
      LOAD_A: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        ld_a     = in_valid && !rst;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        ld_b     = in_valid && !rst;
        clr_p    = in_valid && !rst;
      end
      ADD: begin
        busy  = 1'b1;
        ld_p  = !eqz && !at_max && !rst;
        dec_b = !eqz && !at_max && !rst;
      end
      DONE:    done = 1'b1;
      ERR:     err  = 1'b1;
      default: ;
    endcase
  end

  mul_iter_cnt #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (ld_b),
    .inc_i    (ld_p),
    .cnt_o    (iter_cnt),
    .at_max_o (at_max)
  );

endmodule
